seg7x16_rx: RTL and testbench
=============================

# seg7x16_rx

Receive-side decoder for the 8-digit multiplexed seven-segment bus driven by the `seg7x16` display scanner. It samples the active-low segment/select lines, filters scan transitions, decodes each segment pattern back to a hex nibble, and reassembles the 32-bit word that was displayed. It sits in the test harness next to the board top, letting benches and on-chip checkers read back the CPU result (`reg_12`/`reg_13` halves) from the display pins alone.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted; legal range 1..255.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-low; all state is cleared on a rising `clk` edge while `reset` is 0.
- `i_seg` input 8: segment lines, active-low. Bit 7 is dp; bits 6..0 are g,f,e,d,c,b,a.
- `i_sel` input 8: digit selects, active-low one-hot. `i_sel[k]`=0 selects digit k, which carries nibble bits [4k+3:4k].
- `o_data` output 32: last complete reassembled word.
- `o_valid` output 1: one-cycle pulse when `o_data` updates.
- `o_mask` output 8: digits captured in the current frame.
- `o_bad_pat` output 1: one-cycle pulse on an accepted sample whose pattern is not a hex glyph.
- `o_err_cnt` output 8: saturating count of `o_bad_pat` events.

## Operation
- Sample register holds {`i_sel`,`i_seg`}. A stability counter resets to 1 whenever the sample differs from the previous cycle and increments, saturating, otherwise.
- A sample is accepted exactly once, on the cycle the counter reaches `STABLE_CYCLES`. There is no re-accept until the sample changes.
- Accepted sample with `i_sel` not exactly one zero (blank, or multiple zeros) is ignored: no mask, data, or error change.
- Decode uses `i_seg[6:0]`; dp is ignored. Glyph codes, active-low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Valid glyph: the nibble is written into the shadow word at digit k, and `o_mask[k]` is set. A repeat of the same digit before frame completion overwrites its nibble.
- Invalid glyph: pulse `o_bad_pat`, increment `o_err_cnt` (saturates at 255), and leave mask and shadow untouched.
- Frame completion: when `o_mask` would become 8'hFF, the next cycle loads `o_data` from the shadow (including the completing nibble), pulses `o_valid`, and clears `o_mask` to 0.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_mask`=0, `o_bad_pat`=0, `o_err_cnt`=0, shadow=0, stability counter=0, sample register=all-ones (blank).
- Acceptance latency: `STABLE_CYCLES` cycles after a new sample first appears at the sample register. That register adds 1 cycle from the pins.
- `o_valid` asserts 1 cycle after the acceptance of the completing digit and lasts exactly 1 cycle.
- `o_bad_pat` asserts 1 cycle after the acceptance of the bad sample.
- Frame completion and a new acceptance in the same cycle cannot occur: the minimum spacing is `STABLE_CYCLES`≥1 plus the sample-change cycle.
- Reset mid-frame discards the partial mask and shadow; `o_data` returns to 0.
- A glitch shorter than `STABLE_CYCLES` is never accepted. Returning to the prior sample after a glitch restarts counting, so that digit is accepted again. This is harmless: it overwrites with the same value.

## Configuration
- `SEG7RX_SYNC_EN` defined: two-flop synchronizer on all 16 inputs ahead of the sample register, for asynchronous pins. This adds 2 cycles to every latency above.
- Undefined: inputs are sampled directly. Use this when `i_seg`/`i_sel` are generated in the `clk` domain.

## Structure
- Package `seg7_pkg`:
  - the 16 glyph codes as constants;
  - the decode function returning {valid, nibble};
  - `SEG7_DIGITS`=8.
- Sub-module `seg7rx_stable`: sample register, change detect, saturating counter, and single-cycle `accept` strobe.
- The top handles the one-hot check, decode, shadow/mask, and counters.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random pins -> all outputs 0, `o_mask`=0.
- Loop-back: drive `seg7x16` scanning 32'h1234_5678, `STABLE_CYCLES`=4 -> `o_valid` pulses with `o_data`=32'h1234_5678 once per scan round, never a partial value.
- Glitch: digit 0 steady with glyph 3 (30), inject a 2-cycle glyph 8 (00) -> nibble 0 stays 3, no extra mask bit.
- Bad glyph: digit 5 driven 7F for 6 cycles -> one `o_bad_pat` pulse, `o_err_cnt`=1, `o_mask[5]`=0. After 300 repeats, `o_err_cnt`=255.
- Illegal select: `i_sel`=8'hFC or 8'hFF held 10 cycles -> no mask, data, or error change.
- Reset mid-frame: capture digits 0..3 of 32'hDEAD_BEEF, assert reset 1 cycle, then a full scan of 32'hCAFE_0001 -> single `o_valid` with `o_data`=32'hCAFE_0001.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and glyph decoding for the seven-segment bus receiver.
package seg7_pkg;

  localparam int SEG7_DIGITS = 8;

  // Active-low gfedcba patterns as driven by the display scanner
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Returns {valid, nibble}; valid is 0 for any pattern that is not a hex glyph
  function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      GLYPH_0: res = 5'h10;
      GLYPH_1: res = 5'h11;
      GLYPH_2: res = 5'h12;
      GLYPH_3: res = 5'h13;
      GLYPH_4: res = 5'h14;
      GLYPH_5: res = 5'h15;
      GLYPH_6: res = 5'h16;
      GLYPH_7: res = 5'h17;
      GLYPH_8: res = 5'h18;
      GLYPH_9: res = 5'h19;
      GLYPH_A: res = 5'h1A;
      GLYPH_B: res = 5'h1B;
      GLYPH_C: res = 5'h1C;
      GLYPH_D: res = 5'h1D;
      GLYPH_E: res = 5'h1E;
      GLYPH_F: res = 5'h1F;
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7rx_stable.sv
// Sample register plus stability filter: strobes accept_o once per steady sample.
module seg7rx_stable #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_i,
  output logic [14:0] sample_o,
  output logic        accept_o
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [15:0] sample_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        change;

  // done_q blocks a second accept while the counter sits saturated at STABLE_N
  always_comb begin
    change   = (sample_i != sample_q);
    cnt_d    = cnt_q;
    accept_o = (cnt_q == STABLE_N) && !done_q;
    done_d   = done_q | accept_o;
    if (change) begin
      cnt_d  = 8'd1;
      done_d = 1'b0;
    end else if (cnt_q != 8'hFF) begin
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_q <= 16'hFFFF;
      cnt_q    <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      sample_q <= sample_i;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // dp only matters for change detection, so it is dropped from the output
  assign sample_o = {sample_q[15:8], sample_q[6:0]};

endmodule

// File: rtl/seg7x16_rx.sv
// Seven-segment bus receiver: decodes scanned digits back into a 32-bit word.
// Define SEG7RX_SYNC_EN to add a two-flop synchronizer on the pins.
module seg7x16_rx
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_seg,
  input  logic [SEG7_DIGITS-1:0] i_sel,
  output logic [31:0]            o_data,
  output logic                   o_valid,
  output logic [SEG7_DIGITS-1:0] o_mask,
  output logic                   o_bad_pat,
  output logic [7:0]             o_err_cnt
);

  logic [15:0] pins;

`ifdef SEG7RX_SYNC_EN
  logic [15:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 16'hFFFF;
      sync2_q <= 16'hFFFF;
    end else begin
      sync1_q <= {i_sel, i_seg};
      sync2_q <= sync1_q;
    end
  end

  assign pins = sync2_q;
`else
  assign pins = {i_sel, i_seg};
`endif

  logic [14:0] sample;
  logic        accept;

  seg7rx_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_stable (
    .clk      (clk),
    .reset    (reset),
    .sample_i (pins),
    .sample_o (sample),
    .accept_o (accept)
  );

  logic [31:0]            data_q, data_d;
  logic                   valid_q, valid_d;
  logic [SEG7_DIGITS-1:0] mask_q, mask_d;
  logic                   bad_q, bad_d;
  logic [7:0]             err_q, err_d;
  logic [31:0]            shadow_q, shadow_d;

  logic [SEG7_DIGITS-1:0] selN;
  logic                   oneHot;
  logic [2:0]             idx;
  logic [4:0]             dec;
  logic [SEG7_DIGITS-1:0] maskNext;

  always_comb begin
    selN     = ~sample[14:7];
    oneHot   = (selN != '0) && ((selN & (selN - 8'd1)) == '0);
    dec      = seg7_decode(sample[6:0]);
    maskNext = mask_q | selN;
    idx      = 3'd0;
    for (int k = 0; k < SEG7_DIGITS; k++) begin
      if (selN[k]) idx = 3'(k);
    end

    data_d   = data_q;
    valid_d  = 1'b0;
    mask_d   = mask_q;
    bad_d    = 1'b0;
    err_d    = err_q;
    shadow_d = shadow_q;

    // Completion publishes the shadow including the nibble landing this cycle
    if (accept && oneHot) begin
      if (dec[4]) begin
        shadow_d[{idx, 2'b00} +: 4] = dec[3:0];
        if (maskNext == '1) begin
          data_d  = shadow_d;
          valid_d = 1'b1;
          mask_d  = '0;
        end else begin
          mask_d  = maskNext;
        end
      end else begin
        bad_d = 1'b1;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q   <= 32'd0;
      valid_q  <= 1'b0;
      mask_q   <= '0;
      bad_q    <= 1'b0;
      err_q    <= 8'd0;
      shadow_q <= 32'd0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_mask    = mask_q;
  assign o_bad_pat = bad_q;
  assign o_err_cnt = err_q;

endmodule

// File: tb/tb_seg7x16_rx.sv
// Scoreboard bench for seg7x16_rx: stimulus pushes expected words/error counts, a monitor pops them.
module tb_seg7x16_rx;

  logic        clk;
  logic        reset;
  logic [7:0]  iSeg;
  logic [7:0]  iSel;
  logic [31:0] oData;
  logic        oValid;
  logic [7:0]  oMask;
  logic        oBadPat;
  logic [7:0]  oErrCnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] validQ[$];
  logic [7:0]  badQ[$];

  logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7x16_rx #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_seg     (iSeg),
    .i_sel     (iSel),
    .o_data    (oData),
    .o_valid   (oValid),
    .o_mask    (oMask),
    .o_bad_pat (oBadPat),
    .o_err_cnt (oErrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] sel, input logic [7:0] seg, input int cycles);
    iSel = sel;
    iSeg = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic showDigit(input int k, input logic [3:0] nib, input int cycles);
    logic [7:0] s;
    s = 8'd1 << k;
    applyStimulus(~s, {1'b1, glyphTab[nib]}, cycles);
  endtask

  task automatic scanDigits(input logic [31:0] word, input int first, input int last, input bit completes);
    for (int k = first; k <= last; k++) begin
      if (completes && k == 7) validQ.push_back(word);
      showDigit(k, word[4*k +: 4], 6);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (oValid) begin
      if (validQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got %h expected no pulse", oData);
      end else begin
        checkOutput("valid_data", oData, validQ.pop_front());
      end
    end
    if (oBadPat) begin
      if (badQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_bad_pat: got err_cnt %0d expected no pulse", oErrCnt);
      end else begin
        checkOutput("bad_pat_errcnt", {24'd0, oErrCnt}, {24'd0, badQ.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b0;
    iSel  = $urandom();
    iSeg  = $urandom();
    repeat (3) begin
      @(posedge clk);
      #1;
      iSel = $urandom();
      iSeg = $urandom();
    end
    checkOutput("reset_data", oData, 32'd0);
    checkOutput("reset_valid", {31'd0, oValid}, 32'd0);
    checkOutput("reset_mask", {24'd0, oMask}, 32'd0);
    checkOutput("reset_bad_pat", {31'd0, oBadPat}, 32'd0);
    checkOutput("reset_err_cnt", {24'd0, oErrCnt}, 32'd0);
    iSel  = 8'hFF;
    iSeg  = 8'hFF;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    scanDigits(32'h1234_5678, 0, 7, 1'b1);
    scanDigits(32'h1234_5678, 0, 7, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("loop_mask", {24'd0, oMask}, 32'd0);
    checkOutput("loop_data", oData, 32'h1234_5678);

    showDigit(0, 4'h3, 6);
    showDigit(0, 4'h8, 2);
    showDigit(0, 4'h3, 6);
    showDigit(1, 4'h8, 2);
    showDigit(0, 4'h3, 6);
    checkOutput("glitch_mask", {24'd0, oMask}, 32'h01);
    scanDigits(32'hFEDC_BA93, 1, 7, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("glitch_data", oData, 32'hFEDC_BA93);

    applyStimulus(8'hFC, {1'b1, glyphTab[0]}, 10);
    applyStimulus(8'hFF, 8'h80, 10);
    applyStimulus(8'hFC, 8'hFF, 10);
    checkOutput("illegal_sel_mask", {24'd0, oMask}, 32'd0);
    checkOutput("illegal_sel_err", {24'd0, oErrCnt}, 32'd0);
    checkOutput("illegal_sel_data", oData, 32'hFEDC_BA93);

    badQ.push_back(8'd1);
    applyStimulus(8'hDF, 8'hFF, 6);
    checkOutput("bad_glyph_err1", {24'd0, oErrCnt}, 32'd1);
    checkOutput("bad_glyph_mask5", {31'd0, oMask[5]}, 32'd0);
    for (int n = 2; n <= 300; n++) begin
      applyStimulus(8'hFF, 8'hFF, 5);
      badQ.push_back((n > 255) ? 8'd255 : 8'(n));
      applyStimulus(8'hDF, 8'hFF, 5);
    end
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("bad_glyph_sat", {24'd0, oErrCnt}, 32'd255);

    scanDigits(32'hDEAD_BEEF, 0, 3, 1'b0);
    checkOutput("midframe_mask", {24'd0, oMask}, 32'h0F);
    iSel  = 8'hFF;
    iSeg  = 8'hFF;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("midframe_rst_data", oData, 32'd0);
    checkOutput("midframe_rst_mask", {24'd0, oMask}, 32'd0);
    checkOutput("midframe_rst_err", {24'd0, oErrCnt}, 32'd0);
    applyStimulus(8'hFF, 8'hFF, 4);
    scanDigits(32'hCAFE_0001, 0, 7, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 20);
    checkOutput("final_data", oData, 32'hCAFE_0001);

    checkOutput("valid_queue_drained", validQ.size(), 32'd0);
    checkOutput("bad_queue_drained", badQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
